// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (logical gfedcba, active-high) and the
// readback word-assembly state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG7_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG7_HEX_1 = 7'h06;
    localparam logic [6:0] SEG7_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG7_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG7_HEX_4 = 7'h66;
    localparam logic [6:0] SEG7_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG7_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG7_HEX_7 = 7'h07;
    localparam logic [6:0] SEG7_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG7_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG7_HEX_A = 7'h77;
    localparam logic [6:0] SEG7_HEX_B = 7'h7C;
    localparam logic [6:0] SEG7_HEX_C = 7'h39;
    localparam logic [6:0] SEG7_HEX_D = 7'h5E;
    localparam logic [6:0] SEG7_HEX_E = 7'h79;
    localparam logic [6:0] SEG7_HEX_F = 7'h71;
    localparam logic [6:0] SEG7_BLANK = 7'h00;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } word_state_e;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup: logical segment pattern -> hex nibble,
// with hit (pattern is a known digit) and blank (all segments off) flags.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] value_o,
    output logic       hit_o,
    output logic       blank_o
);

    always_comb begin
        value_o = 4'h0;
        hit_o   = 1'b1;
        blank_o = (pattern_i == SEG7_BLANK);
        case (pattern_i)
            SEG7_HEX_0: value_o = 4'h0;
            SEG7_HEX_1: value_o = 4'h1;
            SEG7_HEX_2: value_o = 4'h2;
            SEG7_HEX_3: value_o = 4'h3;
            SEG7_HEX_4: value_o = 4'h4;
            SEG7_HEX_5: value_o = 4'h5;
            SEG7_HEX_6: value_o = 4'h6;
            SEG7_HEX_7: value_o = 4'h7;
            SEG7_HEX_8: value_o = 4'h8;
            SEG7_HEX_9: value_o = 4'h9;
            SEG7_HEX_A: value_o = 4'hA;
            SEG7_HEX_B: value_o = 4'hB;
            SEG7_HEX_C: value_o = 4'hC;
            SEG7_HEX_D: value_o = 4'hD;
            SEG7_HEX_E: value_o = 4'hE;
            SEG7_HEX_F: value_o = 4'hF;
            default:    hit_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Decodes a scanned 4-digit seven-segment bus back into a 16-bit word.
// Optional decimal-point capture is enabled with `define SEG7_DP_DECODE_EN.
module seg7_readback_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
`ifdef SEG7_DP_DECODE_EN
    input  logic        dp,
    output logic        digit_dp,
    output logic [3:0]  word_dp,
`endif
    output logic        digit_valid,
    output logic [3:0]  digit_val,
    output logic [1:0]  digit_idx,
    output logic        pat_err,
    output logic [15:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        overflow
);

`ifdef SEG7_DP_DECODE_EN
    localparam int SW = 12;
`else
    localparam int SW = 11;
`endif
    localparam logic [7:0] STABLE_C  = STABLE_CYCLES[7:0];
    localparam logic [7:0] STABLE_M1 = STABLE_C - 8'd1;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic [SW-1:0] s_raw, s_d, s_q, s_prev_q;
    logic [7:0]    cnt_q, cnt_d;
    logic          same, accept, onehot, hit, blank, dv;
    logic [3:0]    val;
    logic [1:0]    idx;

`ifdef SEG7_DP_DECODE_EN
    assign s_raw = {dp, an, seg};
`else
    assign s_raw = {an, seg};
`endif
    // Everything downstream of the input register sees active-high lines.
    assign s_d = (SEG_ACTIVE_LOW != 0) ? ~s_raw : s_raw;

    assign same   = (s_q == s_prev_q);
    assign accept = same && (cnt_q == STABLE_M1);
    assign onehot = is_onehot(s_q[10:7]);
    assign idx    = onehot_idx(s_q[10:7]);

    seg7_pattern_lookup u_lookup (
        .pattern_i (s_q[6:0]),
        .value_o   (val),
        .hit_o     (hit),
        .blank_o   (blank)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (!same)
            cnt_d = 8'd0;
        else if (cnt_q != STABLE_C)
            cnt_d = cnt_q + 8'd1;
    end

    assign dv          = accept && onehot && hit;
    assign digit_valid = dv;
    assign pat_err     = accept && onehot && !hit && !blank;
    assign digit_val   = dv ? val : 4'd0;
    assign digit_idx   = dv ? idx : 2'd0;

    word_state_e state_q, state_d;
    logic [3:0]  mask_q, mask_d, mask_new;
    logic [15:0] staging_q, staging_d, word_q, word_d;
    logic        word_valid_q, word_valid_d, overflow_q, overflow_d, full;
`ifdef SEG7_DP_DECODE_EN
    logic [3:0]  stg_dp_q, stg_dp_d, word_dp_q, word_dp_d;
`endif

    // Word assembly: the just-accepted digit counts towards completion.
    always_comb begin
        state_d      = state_q;
        staging_d    = staging_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        overflow_d   = overflow_q;
        mask_new     = mask_q;
`ifdef SEG7_DP_DECODE_EN
        stg_dp_d     = stg_dp_q;
        word_dp_d    = word_dp_q;
`endif
        if (dv) begin
            staging_d[{idx, 2'b00} +: 4] = val;
            mask_new[idx]                = 1'b1;
`ifdef SEG7_DP_DECODE_EN
            stg_dp_d[idx]                = s_q[11];
`endif
        end
        full   = dv && (mask_new == 4'hF);
        mask_d = (full || pat_err) ? 4'd0 : mask_new;

        case (state_q)
            ST_COLLECT: begin
                if (full) begin
                    word_d       = staging_d;
                    word_valid_d = 1'b1;
                    state_d      = ST_PENDING;
`ifdef SEG7_DP_DECODE_EN
                    word_dp_d    = stg_dp_d;
`endif
                end
            end
            ST_PENDING: begin
                if (word_ready && full) begin
                    word_d       = staging_d;
`ifdef SEG7_DP_DECODE_EN
                    word_dp_d    = stg_dp_d;
`endif
                end else if (word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = ST_COLLECT;
                end else if (full) begin
                    overflow_d   = 1'b1;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q          <= '0;
            s_prev_q     <= '0;
            cnt_q        <= 8'd0;
            state_q      <= ST_COLLECT;
            mask_q       <= 4'd0;
            staging_q    <= 16'd0;
            word_q       <= 16'd0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef SEG7_DP_DECODE_EN
            stg_dp_q     <= 4'd0;
            word_dp_q    <= 4'd0;
`endif
        end else begin
            s_q          <= s_d;
            s_prev_q     <= s_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            mask_q       <= mask_d;
            staging_q    <= staging_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
`ifdef SEG7_DP_DECODE_EN
            stg_dp_q     <= stg_dp_d;
            word_dp_q    <= word_dp_d;
`endif
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign overflow   = overflow_q;
`ifdef SEG7_DP_DECODE_EN
    assign digit_dp   = dv ? s_q[11] : 1'b0;
    assign word_dp    = word_dp_q;
`endif

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder (STABLE_CYCLES=4, active-low bus).
module tb_seg7_readback_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic        digit_valid, pat_err, word_valid, overflow;
    logic        word_ready = 1'b0;
    logic [3:0]  digit_val;
    logic [1:0]  digit_idx;
    logic [15:0] word;
`ifdef SEG7_DP_DECODE_EN
    logic        dp = 1'b1;
    logic        digit_dp;
    logic [3:0]  word_dp;
    logic        ev_dp;
`endif

    int checks = 0;
    int errors = 0;
    int ev_cnt, err_cnt, ev_k;
    logic [3:0] ev_val;
    logic [1:0] ev_idx;

    seg7_readback_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
`ifdef SEG7_DP_DECODE_EN
        .dp          (dp),
        .digit_dp    (digit_dp),
        .word_dp     (word_dp),
`endif
        .digit_valid (digit_valid),
        .digit_val   (digit_val),
        .digit_idx   (digit_idx),
        .pat_err     (pat_err),
        .word        (word),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Drive a physical bus pattern from a negedge, observe for `cycles` clocks.
    // word_ready is raised only for the clock numbered ready_k (0 = never).
    task automatic hold(input logic [3:0] an_p, input logic [6:0] seg_p,
                        input int cycles, input int ready_k);
        an = an_p;
        seg = seg_p;
        ev_cnt = 0; err_cnt = 0; ev_k = 0; ev_val = 4'd0; ev_idx = 2'd0;
        for (int k = 1; k <= cycles; k++) begin
            word_ready = (k == ready_k);
            @(posedge clk);
            @(negedge clk);
            word_ready = 1'b0;
            if (digit_valid) begin
                ev_cnt++; ev_k = k; ev_val = digit_val; ev_idx = digit_idx;
`ifdef SEG7_DP_DECODE_EN
                ev_dp = digit_dp;
`endif
            end
            if (pat_err) err_cnt++;
        end
    endtask

    task automatic digit(input int pos, input logic [3:0] v, input int ready_k);
        logic [3:0] one;
        one = 4'b0001 << pos;
        hold(~one, ~seg_of(v), 6, ready_k);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        an = 4'hF;
        seg = 7'h7F;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        an = 4'($urandom);
        seg = 7'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL rst_digit_valid got %b want 0", digit_valid); end
        checks++; if (pat_err !== 1'b0) begin errors++; $display("FAIL rst_pat_err got %b want 0", pat_err); end
        checks++; if (word !== 16'h0) begin errors++; $display("FAIL rst_word got %h want 0000", word); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_word_valid got %b want 0", word_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
        checks++; if ({digit_val, digit_idx} !== 6'd0) begin errors++; $display("FAIL rst_digit got %h want 00", {digit_val, digit_idx}); end
        rst_n = 1'b1;
        hold(4'b1110, ~7'h4F, 10, 0);
        checks++; if (ev_cnt !== 1) begin errors++; $display("FAIL first_digit_count got %0d want 1", ev_cnt); end
        checks++; if (ev_k !== 5) begin errors++; $display("FAIL first_digit_latency got %0d want 5", ev_k); end
        checks++; if (ev_val !== 4'h3 || ev_idx !== 2'd0) begin errors++; $display("FAIL first_digit_value got %h/%0d want 3/0", ev_val, ev_idx); end
    endtask

    task automatic test_glitch();
        int tot_ev = 0, tot_err = 0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            hold(4'b1101, (i % 2 == 0) ? ~7'h06 : ~7'h5B, 3, 0);
            tot_ev += ev_cnt;
            tot_err += err_cnt;
        end
        checks++; if (tot_ev !== 0 || tot_err !== 0) begin errors++; $display("FAIL glitch_events got %0d/%0d want 0/0", tot_ev, tot_err); end
        hold(4'b1101, ~7'h5B, 8, 0);
        checks++; if (ev_cnt !== 1 || ev_val !== 4'h2 || ev_idx !== 2'd1) begin errors++; $display("FAIL glitch_settle got %0d %h %0d want 1 2 1", ev_cnt, ev_val, ev_idx); end
    endtask

    task automatic test_decode();
        logic [3:0] an_t [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_t [4] = '{7'h7C, 7'h71, 7'h3F, 7'h6F};
        logic [3:0] val_t [4] = '{4'hB, 4'hF, 4'h0, 4'h9};
        logic [1:0] idx_t [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            hold(an_t[i], ~seg_t[i], 7, 0);
            checks++;
            if (ev_cnt !== 1 || ev_val !== val_t[i] || ev_idx !== idx_t[i]) begin
                errors++;
                $display("FAIL decode_%0d got n=%0d val=%h idx=%0d want n=1 val=%h idx=%0d", i, ev_cnt, ev_val, ev_idx, val_t[i], idx_t[i]);
            end
        end
    endtask

    task automatic test_bad_anodes();
        apply_reset();
        hold(4'b1100, ~7'h06, 10, 0);
        checks++; if (ev_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL two_anodes got %0d/%0d want 0/0", ev_cnt, err_cnt); end
        hold(4'b1110, 7'h7F, 10, 0);
        checks++; if (ev_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL blank got %0d/%0d want 0/0", ev_cnt, err_cnt); end
        hold(4'b1111, ~7'h06, 10, 0);
        checks++; if (ev_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL no_anode got %0d/%0d want 0/0", ev_cnt, err_cnt); end
    endtask

    task automatic test_word_handshake();
        apply_reset();
        digit(3, 4'h1, 0); digit(2, 4'h2, 0); digit(1, 4'h3, 0); digit(0, 4'hA, 0);
        checks++; if (word_valid !== 1'b1 || word !== 16'h123A) begin errors++; $display("FAIL word_done got %b %h want 1 123A", word_valid, word); end
        hold(4'hF, 7'h7F, 5, 0);
        checks++; if (word_valid !== 1'b1 || word !== 16'h123A) begin errors++; $display("FAIL word_hold got %b %h want 1 123A", word_valid, word); end
        word_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word_ready = 1'b0;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL word_accept got %b want 0", word_valid); end
    endtask

    task automatic test_overflow();
        apply_reset();
        digit(3, 4'h1, 0); digit(2, 4'h2, 0); digit(1, 4'h3, 0); digit(0, 4'hA, 0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
        digit(3, 4'h4, 0); digit(2, 4'h5, 0); digit(1, 4'h6, 0); digit(0, 4'h7, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        checks++; if (word !== 16'h123A || word_valid !== 1'b1) begin errors++; $display("FAIL ovf_word got %h %b want 123A 1", word, word_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (overflow !== 1'b0 || word_valid !== 1'b0) begin errors++; $display("FAIL async_reset got %b %b want 0 0", overflow, word_valid); end
        apply_reset();
    endtask

    task automatic test_ready_collide();
        apply_reset();
        digit(3, 4'h1, 0); digit(2, 4'h2, 0); digit(1, 4'h3, 0); digit(0, 4'h4, 0);
        digit(3, 4'h8, 0); digit(2, 4'h9, 0); digit(1, 4'hA, 0); digit(0, 4'hB, 6);
        checks++; if (word !== 16'h89AB || word_valid !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL collide got %h %b %b want 89AB 1 0", word, word_valid, overflow);
        end
    endtask

    task automatic test_bad_pattern();
        apply_reset();
        digit(3, 4'h1, 0); digit(2, 4'h2, 0);
        hold(4'b1101, ~7'h49, 8, 0);
        checks++; if (err_cnt !== 1 || ev_cnt !== 0) begin errors++; $display("FAIL bad_pat got err=%0d ev=%0d want 1 0", err_cnt, ev_cnt); end
        digit(1, 4'h3, 0); digit(0, 4'hA, 0);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL bad_pat_abort got %b want 0", word_valid); end
        digit(3, 4'h5, 0); digit(2, 4'h6, 0);
        checks++; if (word_valid !== 1'b1 || word !== 16'h563A) begin errors++; $display("FAIL bad_pat_refill got %b %h want 1 563A", word_valid, word); end
    endtask

`ifdef SEG7_DP_DECODE_EN
    task automatic test_dp();
        apply_reset();
        digit(3, 4'h1, 0); digit(2, 4'h2, 0); digit(1, 4'h3, 0);
        dp = 1'b0;
        digit(0, 4'h4, 0);
        dp = 1'b1;
        checks++; if (ev_dp !== 1'b1) begin errors++; $display("FAIL digit_dp got %b want 1", ev_dp); end
        checks++; if (word_dp !== 4'b0001) begin errors++; $display("FAIL word_dp got %b want 0001", word_dp); end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_decode();
        test_bad_anodes();
        test_word_handshake();
        test_overflow();
        test_ready_collide();
        test_bad_pattern();
`ifdef SEG7_DP_DECODE_EN
        test_dp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
